mem_port_arbiter: RTL and testbench

- Arbitrates the single external memory port between the fetch stage (instruction reads) and the memory stage (data loads and stores).
- Sequences each access through a request/acknowledge handshake with memory.
- Returns read data and a one-cycle ready pulse to the winning requester.
- Enforces data-side priority, bounded by an anti-starvation counter for fetch; supports squashing an in-flight fetch on a PC redirect.

---
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between instruction fetch and the data stage.
// Data has priority; a saturating wait counter forces a fetch grant after MAX_WAIT data grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_byte,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RESP_I,
        RESP_D
    } state_t;

    state_t     state, state_nx;
    logic [3:0] wait_cnt;
    logic       drop;
    logic       fetch_ok;
    logic       starve;

    assign fetch_ok = i_req && !i_flush;
    assign starve   = fetch_ok && (wait_cnt >= MAX_WAIT_C);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        i_ready  = 1'b0;
        d_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !starve) begin
                    state_nx = SERVE_D;
                end else if (fetch_ok) begin
                    state_nx = SERVE_I;
                end
            end
            SERVE_I: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    // a flush seen at any point of the access squashes the response
                    state_nx = (drop || i_flush) ? IDLE : RESP_I;
                end
            end
            SERVE_D: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_nx = RESP_D;
                end
            end
            RESP_I: begin
                i_ready  = !i_flush;
                state_nx = IDLE;
            end
            RESP_D: begin
                d_ready  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_we    <= 1'b0;
            mem_byte  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            wait_cnt  <= '0;
            drop      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nx == SERVE_D) begin
                        mem_we    <= d_we;
                        mem_byte  <= d_byte;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (fetch_ok) begin
                            if (wait_cnt != 4'd15) begin
                                wait_cnt <= wait_cnt + 4'd1;
                            end
                        end else if (!i_req) begin
                            wait_cnt <= '0;
                        end
                    end else if (state_nx == SERVE_I) begin
                        mem_we    <= 1'b0;
                        mem_byte  <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        wait_cnt  <= '0;
                        drop      <= 1'b0;
                    end else if (!i_req) begin
                        wait_cnt <= '0;
                    end
                end
                SERVE_I: begin
                    if (i_flush) begin
                        drop <= 1'b1;
                    end
                    if (mem_ack && !drop && !i_flush) begin
                        i_rdata <= mem_rdata;
                    end
                end
                SERVE_D: begin
                    if (mem_ack) begin
                        d_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level reference model of grants,
// memory timing, flush squashing and readiness, plus an asynchronous reset mid data access.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_req, i_flush, i_ready;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_byte, d_ready;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_req, mem_we, mem_byte, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MAX_WAIT(MW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_flush  (i_flush),
        .i_ready  (i_ready),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_byte   (d_byte),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_byte (mem_byte),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the access currently owning the port (0 none, 1 fetch, 2 data),
    // whether memory has answered, and whether a flush has squashed the fetch.
    int          m_owner;
    bit          m_answered;
    bit          m_squashed;
    int          m_starve;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit          m_we, m_byte;
    logic [DW-1:0] m_irdata, m_drdata;

    // Requester state: pending request contents held until ready.
    bit            ip, dp;
    logic [AW-1:0] ia, da;
    bit            dwe, dby;
    logic [DW-1:0] dwd;
    int            req_pct;
    int            flush_pct;

    task automatic model_reset();
        m_owner    = 0;
        m_answered = 0;
        m_squashed = 0;
        m_starve   = 0;
        m_addr     = '0;
        m_wdata    = '0;
        m_we       = 0;
        m_byte     = 0;
        m_irdata   = '0;
        m_drdata   = '0;
        ip         = 0;
        dp         = 0;
    endtask

    task automatic clear_inputs();
        i_req     = 0;
        i_addr    = '0;
        i_flush   = 0;
        d_req     = 0;
        d_we      = 0;
        d_byte    = 0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ack   = 0;
        mem_rdata = '0;
    endtask

    task automatic drive_cycle();
        if (!ip && $urandom_range(0, 99) < req_pct) begin
            ip = 1;
            ia = $urandom & 32'hFFFF_FFFC;
        end
        if (!dp && $urandom_range(0, 99) < req_pct) begin
            dp  = 1;
            dwe = 1'($urandom_range(0, 1));
            dby = 1'($urandom_range(0, 1));
            da  = $urandom;
            dwd = $urandom;
        end
        i_req   = ip;
        i_addr  = ia;
        d_req   = dp;
        d_we    = dwe;
        d_byte  = dby;
        d_addr  = da;
        d_wdata = dwd;
        i_flush = ($urandom_range(0, 99) < flush_pct);
        if (m_owner != 0 && !m_answered) mem_ack = ($urandom_range(0, 2) == 0);
        else                             mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
    endtask

    task automatic check_and_step();
        bit e_mreq, e_ir, e_dr, fetch_ok;
        e_mreq = (m_owner != 0) && !m_answered;
        e_ir   = (m_owner == 1) && m_answered && !i_flush;
        e_dr   = (m_owner == 2) && m_answered;
        check("mem_req", 64'(mem_req), 64'(e_mreq));
        check("i_ready", 64'(i_ready), 64'(e_ir));
        check("d_ready", 64'(d_ready), 64'(e_dr));
        check("i_rdata", 64'(i_rdata), 64'(m_irdata));
        check("d_rdata", 64'(d_rdata), 64'(m_drdata));
        if (e_mreq) begin
            check("mem_addr", 64'(mem_addr), 64'(m_addr));
            check("mem_we", 64'(mem_we), 64'(m_we));
            check("mem_byte", 64'(mem_byte), 64'(m_byte));
            if (m_we) check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end

        if (m_owner == 0) begin
            fetch_ok = ip && !i_flush;
            if (dp && !(fetch_ok && m_starve >= MW)) begin
                m_owner = 2;
                m_addr  = da;
                m_we    = dwe;
                m_byte  = dby;
                m_wdata = dwd;
                if (fetch_ok)  m_starve = (m_starve < 15) ? m_starve + 1 : 15;
                else if (!ip)  m_starve = 0;
            end else if (fetch_ok) begin
                m_owner    = 1;
                m_squashed = 0;
                m_addr     = ia;
                m_we       = 0;
                m_byte     = 0;
                m_starve   = 0;
            end else if (!ip) begin
                m_starve = 0;
            end
        end else if (!m_answered) begin
            if (m_owner == 1 && i_flush) m_squashed = 1;
            if (mem_ack) begin
                if (m_owner == 2) begin
                    m_drdata   = mem_rdata;
                    m_answered = 1;
                end else if (m_squashed) begin
                    m_owner = 0;
                end else begin
                    m_irdata   = mem_rdata;
                    m_answered = 1;
                end
            end
        end else begin
            m_owner    = 0;
            m_answered = 0;
        end

        if (e_ir)    ip = 0;
        if (e_dr)    dp = 0;
        if (i_flush) ip = 0;
    endtask

    task automatic run_cycle();
        @(posedge clock);
        #1;
        drive_cycle();
        @(negedge clock);
        check_and_step();
    endtask

    initial begin
        bit reset_done;
        clear_inputs();
        model_reset();
        dwe = 0; dby = 0; ia = '0; da = '0; dwd = '0;
        req_pct   = 0;
        flush_pct = 0;

        repeat (3) @(negedge clock);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_i_ready", 64'(i_ready), 64'd0);
        check("rst_d_ready", 64'(d_ready), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_i_rdata", 64'(i_rdata), 64'd0);
        check("rst_d_rdata", 64'(d_rdata), 64'd0);
        reset = 1'b1;

        // Both requesters always busy, no flushes: exercises the starvation limit.
        req_pct = 100;
        repeat (200) run_cycle();

        // General mix with flushes and spurious acknowledges.
        req_pct   = 40;
        flush_pct = 8;
        repeat (1500) run_cycle();

        // Asynchronous reset while a data access is on the port.
        req_pct    = 60;
        flush_pct  = 0;
        reset_done = 0;
        for (int c = 0; c < 300 && !reset_done; c++) begin
            @(posedge clock);
            #1;
            drive_cycle();
            if (m_owner == 2 && !m_answered) begin
                #2 reset = 1'b0;
                #1;
                check("arst_mem_req", 64'(mem_req), 64'd0);
                check("arst_i_ready", 64'(i_ready), 64'd0);
                check("arst_d_ready", 64'(d_ready), 64'd0);
                check("arst_mem_addr", 64'(mem_addr), 64'd0);
                clear_inputs();
                model_reset();
                repeat (2) @(posedge clock);
                @(negedge clock);
                reset      = 1'b1;
                reset_done = 1;
            end else begin
                @(negedge clock);
                check_and_step();
            end
        end
        check("reset_window_hit", 64'(reset_done), 64'd1);

        req_pct = 0;
        repeat (10) run_cycle();

        req_pct   = 70;
        flush_pct = 5;
        repeat (600) run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
